// File: rtl/lmfe_pkg.sv
// Shared LMFE constants used by the controller and the median sorter.
//   DW    : pixel width in bits
//   NUM   : window element count (7x7 window)
//   MID   : median slot index, derived from NUM
//   CW    : occupancy counter width, 2**CW > NUM
//   SE_ON : asserted level of the active-low sort enable
package lmfe_pkg;

    localparam int unsigned DW  = 8;
    localparam int unsigned NUM = 49;
    localparam int unsigned MID = (NUM - 1) / 2;
    localparam int unsigned CW  = 6;

    localparam logic SE_ON = 1'b0;

endpackage : lmfe_pkg

// File: rtl/lmfe_sort_cell.sv
// One slot of the parallel sorted list: picks the slot's next value from
// its lower neighbour, itself, its upper neighbour or the inserted pixel.
//   i_prev / i_self / i_next : slots i-1, i, i+1 (ends tied off by parent)
//   i_ins                    : value being inserted
//   i_gt_prev/self/next      : ins_gt flags (slot > INS) of i-1, i, i+1
//   i_dp_prev / i_dp_self    : del_pos flags (at or above the removed slot)
//   o_next_c                 : combinational next value for slot i
module lmfe_sort_cell
    import lmfe_pkg::*;
#(
    parameter int unsigned W = DW
) (
    input  logic [W-1:0] i_prev,
    input  logic [W-1:0] i_self,
    input  logic [W-1:0] i_next,
    input  logic [W-1:0] i_ins,
    input  logic         i_gt_prev,
    input  logic         i_gt_self,
    input  logic         i_gt_next,
    input  logic         i_dp_prev,
    input  logic         i_dp_self,
    output logic [W-1:0] o_next_c
);

    logic         w_gt_here;
    logic         w_gt_below;
    logic [W-1:0] w_keep;
    logic [W-1:0] w_shift;

    // Once at or above the deleted slot, the list with the deletion applied
    // is the old list read one slot higher; the insert then works on that view.
    always_comb begin
        w_gt_here  = i_gt_self;
        w_gt_below = i_gt_prev;
        w_keep     = i_self;
        w_shift    = i_prev;
        if (i_dp_self) begin
            w_gt_here  = i_gt_next;
            w_keep     = i_next;
            // At exactly the deleted slot the lower view element is i-1 itself.
            w_gt_below = i_dp_prev ? i_gt_self : i_gt_prev;
            w_shift    = i_dp_prev ? i_self    : i_prev;
        end
    end

    // Element below INS stays, first element above INS yields INS, the rest shift up.
    always_comb begin
        o_next_c = w_keep;
        if (w_gt_here) begin
            o_next_c = w_gt_below ? w_shift : i_ins;
        end
    end

endmodule : lmfe_sort_cell

// File: rtl/lmfe_median_sorter.sv
// Median engine for the LMFE 7x7 window: keeps the window as an ascending
// sorted list and updates it in a single clock per SE==0 cycle (insert only
// while filling, delete-and-insert once full).
//   clk  : rising-edge clock
//   RST  : asynchronous active-high reset
//   SE   : active-low sort enable
//   INS  : pixel to insert
//   DEL  : pixel to remove (used only once the list is full)
//   MED  : median slot of the list (register)
//   FULL : list holds NUM entries (register)
//   ERR  : sticky, DEL was not found during a steady-state update
module lmfe_median_sorter #(
    parameter int unsigned DW  = lmfe_pkg::DW,
    parameter int unsigned NUM = lmfe_pkg::NUM,
    parameter int unsigned CW  = lmfe_pkg::CW
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          SE,
    input  logic [DW-1:0] INS,
    input  logic [DW-1:0] DEL,
    output logic [DW-1:0] MED,
    output logic          FULL,
    output logic          ERR
);

    localparam int unsigned MID = (NUM - 1) / 2;

    logic [DW-1:0]  r_slot [NUM];
    logic [CW-1:0]  r_count;
    logic           r_full;
    logic           r_err;

    logic [DW-1:0]  w_next [NUM];
    logic [NUM-1:0] w_gt;
    logic [NUM-1:0] w_match;
    logic [NUM-1:0] w_dp;
    logic [NUM-1:0] w_wr;
    logic           w_upd;
    logic           w_absent;

    assign w_upd = (SE == lmfe_pkg::SE_ON);

    // Per-slot flags; empty slots during fill behave as +infinity.
    always_comb begin
        logic w_acc;
        w_gt    = '0;
        w_match = '0;
        w_dp    = '0;
        w_wr    = '0;
        w_acc   = 1'b0;
        for (int i = 0; i < int'(NUM); i++) begin
            if (r_full || (CW'(i) < r_count)) begin
                w_gt[i] = (r_slot[i] > INS);
            end else begin
                w_gt[i] = 1'b1;
            end
            w_match[i] = r_full && (r_slot[i] == DEL);
            w_acc      = w_acc | w_match[i];
            w_dp[i]    = w_acc;
            w_wr[i]    = r_full || (CW'(i) <= r_count);
        end
        // With no DEL copy present the top slot is the one dropped.
        w_dp[NUM-1] = r_full;
    end

    assign w_absent = r_full && !(|w_match);

    // One compare-and-select cell per slot.
    for (genvar g = 0; g < int'(NUM); g++) begin : g_cell
        logic [DW-1:0] w_sp;
        logic [DW-1:0] w_sn;
        logic          w_gp;
        logic          w_gn;
        logic          w_dpp;

        if (g == 0) begin : g_lo
            assign w_sp  = '0;
            assign w_gp  = 1'b0;
            assign w_dpp = 1'b0;
        end else begin : g_lo
            assign w_sp  = r_slot[g-1];
            assign w_gp  = w_gt[g-1];
            assign w_dpp = w_dp[g-1];
        end

        if (g == int'(NUM) - 1) begin : g_hi
            assign w_sn = '0;
            assign w_gn = 1'b1;
        end else begin : g_hi
            assign w_sn = r_slot[g+1];
            assign w_gn = w_gt[g+1];
        end

        lmfe_sort_cell #(
            .W (DW)
        ) u_cell (
            .i_prev    (w_sp),
            .i_self    (r_slot[g]),
            .i_next    (w_sn),
            .i_ins     (INS),
            .i_gt_prev (w_gp),
            .i_gt_self (w_gt[g]),
            .i_gt_next (w_gn),
            .i_dp_prev (w_dpp),
            .i_dp_self (w_dp[g]),
            .o_next_c  (w_next[g])
        );
    end

    // List, occupancy and status registers.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM); i++) begin
                r_slot[i] <= '0;
            end
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_upd) begin
            for (int i = 0; i < int'(NUM); i++) begin
                if (w_wr[i]) begin
                    r_slot[i] <= w_next[i];
                end
            end
            if (!r_full) begin
                r_count <= r_count + CW'(1);
            end
            if (r_count == CW'(NUM - 1)) begin
                r_full <= 1'b1;
            end
            if (w_absent) begin
                r_err <= 1'b1;
            end
        end
    end

    assign MED  = r_slot[MID];
    assign FULL = r_full;
    assign ERR  = r_err;

endmodule : lmfe_median_sorter

// File: tb/tb_lmfe_median_sorter.sv
// Directed bench for lmfe_median_sorter with a queue-based reference model.
module tb_lmfe_median_sorter;

    localparam int N    = 49;
    localparam int MIDX = 24;

    logic       clk = 1'b0;
    logic       RST;
    logic       SE;
    logic [7:0] INS;
    logic [7:0] DEL;
    logic [7:0] MED;
    logic       FULL;
    logic       ERR;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    logic [7:0] m_mem [N];
    int         m_cnt;
    bit         m_full;
    bit         m_err;

    always #5 clk = ~clk;

    lmfe_median_sorter dut (
        .clk  (clk),
        .RST  (RST),
        .SE   (SE),
        .INS  (INS),
        .DEL  (DEL),
        .MED  (MED),
        .FULL (FULL),
        .ERR  (ERR)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the valid part of the window as a sorted queue.
    task automatic model_update(input logic [7:0] ins, input logic [7:0] del);
        logic [7:0] q[$];
        int idx;
        for (int i = 0; i < m_cnt; i++) q.push_back(m_mem[i]);
        if (m_full) begin
            idx = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (idx < 0 && q[i] == del) idx = i;
            end
            if (idx >= 0) begin
                q.delete(idx);
            end else begin
                q.delete(q.size() - 1);
                m_err = 1'b1;
            end
        end
        idx = q.size();
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] > ins) idx = i;
        end
        q.insert(idx, ins);
        for (int i = 0; i < q.size(); i++) m_mem[i] = q[i];
        if (!m_full) m_cnt++;
        m_full = (m_cnt == N);
    endtask

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N; i++) m_mem[i] = 8'd0;
            m_cnt  = 0;
            m_full = 1'b0;
            m_err  = 1'b0;
        end else if (SE == 1'b0) begin
            model_update(INS, DEL);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            int bad_i;
            bad_i = -1;
            check("MED", MED, m_mem[MIDX]);
            check("FULL", FULL, m_full);
            check("ERR", ERR, m_err);
            for (int i = N - 1; i >= 0; i--) begin
                if (dut.r_slot[i] !== m_mem[i]) bad_i = i;
            end
            if (bad_i >= 0) check("slot", dut.r_slot[bad_i], m_mem[bad_i]);
            else            check("slots", 0, 0 + (bad_i + 1));
        end
    end

    task automatic upd(input logic [7:0] ins, input logic [7:0] del);
        @(negedge clk);
        SE  = 1'b0;
        INS = ins;
        DEL = del;
        @(posedge clk);
        #1;
        SE  = 1'b1;
        INS = 8'($urandom);
        DEL = 8'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        RST = 1'b1;
        #1;
        check("rst_MED", MED, 0);
        check("rst_FULL", FULL, 0);
        check("rst_ERR", ERR, 0);
        @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic fill_desc();
        for (int k = 0; k < N; k++) begin
            upd(8'(48 - k), 8'hFF);
            if (k == N - 2) check("fill_FULL_edge48", FULL, 0);
        end
    endtask

    initial begin
        logic [7:0] med_hold;
        RST = 1'b1;
        SE  = 1'b1;
        INS = 8'hFF;
        DEL = 8'hFF;
        #12;
        check("init_MED", MED, 0);
        check("init_FULL", FULL, 0);
        check("init_ERR", ERR, 0);
        @(negedge clk);
        RST    = 1'b0;
        chk_on = 1'b1;

        // Fill 48..0 then slide.
        fill_desc();
        check("fill_MED", MED, 24);
        check("fill_FULL", FULL, 1);
        check("fill_ERR", ERR, 0);

        med_hold = MED;
        repeat (20) begin
            @(negedge clk);
            SE  = 1'b1;
            INS = 8'($urandom);
            DEL = 8'($urandom);
        end
        #1;
        check("idle_MED", MED, med_hold);
        check("idle_FULL", FULL, 1);
        check("idle_ERR", ERR, 0);

        upd(8'd100, 8'd0);
        check("slide_MED", MED, 25);
        check("slide_s48", dut.r_slot[48], 100);
        check("slide_s0", dut.r_slot[0], 1);
        check("slide_ERR", ERR, 0);

        // Missing DEL.
        do_reset();
        fill_desc();
        upd(8'd5, 8'd200);
        check("miss_ERR", ERR, 1);
        check("miss_MED", MED, 23);
        check("miss_s5", dut.r_slot[5], 5);
        check("miss_s6", dut.r_slot[6], 5);
        check("miss_s48", dut.r_slot[48], 47);
        upd(8'd60, 8'd0);
        upd(8'd61, 8'd60);
        check("miss_ERR_sticky", ERR, 1);

        // Duplicates; DEL equal to stored values during fill is ignored.
        do_reset();
        for (int k = 0; k < N; k++) upd(8'd7, 8'd7);
        check("dup_FULL", FULL, 1);
        upd(8'd200, 8'd7);
        check("dup_MED", MED, 7);
        check("dup_s48", dut.r_slot[48], 200);
        upd(8'd7, 8'd200);
        for (int i = 0; i < N; i++) check("dup_all7", dut.r_slot[i], 7);
        upd(8'd7, 8'd7);
        check("dup_same_s0", dut.r_slot[0], 7);
        upd(8'd3, 8'd7);
        check("dup_low_s0", dut.r_slot[0], 3);
        check("dup_low_s1", dut.r_slot[1], 7);

        // Reset mid-fill, then refill of 255 with one idle gap.
        do_reset();
        for (int k = 0; k < 30; k++) upd(8'(k * 5), 8'hFF);
        do_reset();
        for (int k = 0; k < N; k++) begin
            upd(8'd255, 8'hFF);
            if (k == 10) @(negedge clk);
            if (k == N - 2) check("refill_FULL_late", FULL, 0);
        end
        check("refill_MED", MED, 255);
        check("refill_FULL", FULL, 1);
        check("refill_ERR", ERR, 0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_lmfe_median_sorter

// File: doc/lmfe_median_sorter.md
Name: lmfe_median_sorter

Overview:
- Median engine on the sorter side of the LMFE controller's SE/INS/DEL/MED interface; the controller drives that interface and this block responds to it.
- Holds the current 7x7 window (49 pixels) as an ascending sorted list.
- Fill phase: on each enabled cycle, inserts one pixel.
- Steady state: on each enabled cycle, deletes one old pixel and inserts one new pixel, so the controller can slide the window one row or column per 7 updates.
- MED always presents the middle element of the list.

Parameters:
- DW, 8, pixel width in bits.
- NUM, 49, window element count (odd, >=3).
- MID, (NUM-1)/2 = 24, median slot index; derived, not overridable.
- CW, 6, occupancy counter width; must satisfy 2^CW > NUM.

Ports:
- clk  in  1  clock, rising-edge.
- RST  in  1  asynchronous active-high reset.
- SE  in  1  sort enable, active-low; update occurs on a clk edge where SE==0.
- INS  in  DW  value to insert; sampled when SE==0.
- DEL  in  DW  value to remove; sampled when SE==0 and FULL==1, ignored otherwise.
- MED  out  DW  sorted slot MID, driven directly from register.
- FULL  out  1  occupancy == NUM.
- ERR  out  1  sticky; set on a steady-state update where DEL was absent from the list.

Behaviour:
- Reset is asynchronous, RST only. Reset values: all slots s[0..NUM-1]=0, count=0, MED=0, FULL=0, ERR=0.
- RST asserted mid-operation aborts immediately; the next SE==0 cycle is treated as the first fill insert. No synchronous clear exists.
- SE==1: list, count and ERR hold; INS and DEL are don't-care. The idle pattern 8'hFF on INS/DEL has no special meaning.
- Fill phase (count<NUM, SE==0):
  - INS is inserted into s[0..count] at its sorted position; entries >= INS shift up one slot; count increments.
  - DEL is ignored, even if 8'hFF or equal to a stored value.
  - Slots >= count+1 keep their prior contents.
- Steady state (count==NUM, SE==0):
  - The new list is ascending sort(old list minus one instance of DEL, plus INS).
  - Duplicates are legal; exactly one copy of DEL is removed, the lowest-index match.
  - If DEL==INS, the list is unchanged.
  - INS below or above every entry lands at s[0] or s[NUM-1] respectively.
- DEL absent in steady state: ERR<=1 (sticky until RST). s[NUM-1] is dropped instead of a DEL copy, INS is inserted, and count stays NUM.
- Latency: one full update per clock, no back-pressure. The list and MED reflect an update on the edge that consumes it. The controller may sample MED the cycle after its last SE==0 cycle.
- FULL rises on the same edge that makes count==NUM and stays 1 until RST.
- Ordering invariant: s[i] <= s[i+1] for all i < count-1, at every clock edge.
- Arithmetic: unsigned DW-bit compares only; no arithmetic on pixel values. count saturates at NUM.
- Implementation: one parallel compare-and-select step per slot, with per-slot flags ins_gt (s[i] > INS) and del_pos (i >= first DEL match). Each slot chooses among s[i-1], s[i], s[i+1] and INS. No iterative or multi-cycle sort.

Decomposition:
- Shared package lmfe_pkg: DW, NUM, MID and CW constants, plus the SE active-low polarity constant SE_ON=1'b0. These are common with the LMFE controller.
- One sub-module, lmfe_sort_cell:
  - Inputs: its own slot and both neighbouring slots, INS, and its own and the neighbours' ins_gt/del_pos flags.
  - Outputs: the next slot value.
  - Instantiated NUM times by generate.

Test Plan:
- Fill: after RST, drive SE=0 for 49 cycles with INS=48,47,...,0 and DEL=8'hFF. Expect MED=24 and FULL=1 after the 49th edge, FULL=0 through edge 48, and ERR=0 throughout.
- Slide: from the list {0..48}, apply SE=0, DEL=0, INS=100. Expect MED=25, s[48]=100, s[0]=1, ERR=0.
- Duplicates: fill with 49 copies of 7, then apply DEL=7, INS=200. Expect MED=7 and s[48]=200. Then apply DEL=200, INS=7; expect all slots equal 7.
- Idle/hold: with SE=1 for 20 cycles and random INS/DEL, MED, FULL and ERR must not change. Also, an SE=1 cycle inserted between fill updates delays FULL by exactly one cycle.
- Missing DEL: full list {0..48}, apply DEL=200, INS=5. Expect ERR=1 sticky, old 48 dropped, two 5s present, MED=23. ERR stays 1 across later valid updates.
- Reset mid-fill: assert RST asynchronously after 30 inserts. Expect MED=0, FULL=0, ERR=0 immediately. A fresh 49-insert fill of 255 then gives MED=255, FULL=1.
